// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture path.
package scope_pkg;

  localparam int unsigned DEPTH_DEF = 512;
  localparam int unsigned AW_DEF    = 9;
  localparam int unsigned DW_DEF    = 8;

  // Trigger settings shared with the capture core.
  localparam int unsigned TRIG_THRESHOLD = 128;
  localparam int unsigned PRE_LEN        = 64;
  localparam int unsigned POST_LEN       = 448;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArm     = 3'd1,
    StCapture = 3'd2,
    StLoad    = 3'd3,
    StRdReq   = 3'd4,
    StRdWait  = 3'd5,
    StSend    = 3'd6,
    StRelease = 3'd7
  } state_e;

endpackage

// File: rtl/scope_tx_reg.sv
// Valid/ready output register for the readout byte stream.
module scope_tx_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_last
);

  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_last;

  // Clear (transfer or abort) takes priority over a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/scope_capture_ctrl.sv
// Capture sequencer: arms the core, records samples into the circular RAM,
// streams the captured window out and releases the core.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_arm,
  input  logic          i_cont,
  input  logic          i_abort,
  output logic          o_idle,
  output logic          o_start,
  output logic          o_stop,
  output logic          o_core_rst,
  input  logic          i_busy,
  input  logic          i_done,
  input  logic [DW-1:0] i_adc_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_valid,
  output logic          o_tx_last,
  input  logic          i_tx_ready
);

  localparam logic [AW:0] Full   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CntOne = (AW+1)'(1);

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [AW-1:0] r_rd_ptr, w_rd_ptr_d;
  logic [AW:0]   r_count, w_count_d;
  logic [AW:0]   r_remaining, w_remaining_d;
  logic          r_wr_en, w_wr_en_d;
  logic [AW-1:0] r_wr_addr, w_wr_addr_d;
  logic [DW-1:0] r_wr_data, w_wr_data_d;
  logic          r_core_rst, w_core_rst_d;
  logic          r_idle, r_start, r_stop;
  logic          w_tx_load, w_tx_clear, w_tx_last_d, w_tx_valid;

  // Next-state, pointer and output decode; abort overrides everything.
  always_comb begin
    w_state_d     = r_state;
    w_wr_ptr_d    = r_wr_ptr;
    w_rd_ptr_d    = r_rd_ptr;
    w_count_d     = r_count;
    w_remaining_d = r_remaining;
    w_wr_en_d     = 1'b0;
    w_wr_addr_d   = r_wr_addr;
    w_wr_data_d   = r_wr_data;
    w_core_rst_d  = 1'b0;
    w_tx_load     = 1'b0;
    w_tx_clear    = 1'b0;
    w_tx_last_d   = (r_remaining == CntOne);

    if (i_abort) begin
      w_state_d     = StIdle;
      w_wr_ptr_d    = '0;
      w_rd_ptr_d    = '0;
      w_count_d     = '0;
      w_remaining_d = '0;
      w_core_rst_d  = 1'b1;
      w_tx_clear    = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_arm) begin
            w_state_d  = StArm;
            w_wr_ptr_d = '0;
            w_count_d  = '0;
          end
        end
        StArm: begin
          if (i_busy) w_state_d = StCapture;
        end
        StCapture: begin
          if (i_done) begin
            w_state_d = StLoad;
          end else if (i_busy) begin
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = r_wr_ptr;
            w_wr_data_d = i_adc_data;
            w_wr_ptr_d  = r_wr_ptr + 1'b1;
            if (r_count != Full) w_count_d = r_count + 1'b1;
          end
        end
        StLoad: begin
          // A full buffer starts at the oldest sample, which is at wr_ptr.
          w_rd_ptr_d    = (r_count == Full) ? r_wr_ptr : '0;
          w_remaining_d = r_count;
          w_state_d     = (r_count == '0) ? StRelease : StRdReq;
        end
        StRdReq: begin
          w_state_d = StRdWait;
        end
        StRdWait: begin
          w_tx_load = 1'b1;
          w_state_d = StSend;
        end
        StSend: begin
          if (w_tx_valid && i_tx_ready) begin
            w_tx_clear    = 1'b1;
            w_rd_ptr_d    = r_rd_ptr + 1'b1;
            w_remaining_d = r_remaining - 1'b1;
            w_state_d     = (r_remaining > CntOne) ? StRdReq : StRelease;
          end
        end
        StRelease: begin
          if (!i_done) begin
            if (i_cont) begin
              w_state_d  = StArm;
              w_wr_ptr_d = '0;
              w_count_d  = '0;
            end else begin
              w_state_d = StIdle;
            end
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_core_rst  <= 1'b0;
      r_idle      <= 1'b1;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_remaining <= w_remaining_d;
      r_wr_en     <= w_wr_en_d;
      r_wr_addr   <= w_wr_addr_d;
      r_wr_data   <= w_wr_data_d;
      r_core_rst  <= w_core_rst_d;
      r_idle      <= (w_state_d == StIdle);
      r_start     <= (w_state_d == StArm);
      r_stop      <= (w_state_d == StRelease);
    end
  end

  scope_tx_reg #(
    .DW (DW)
  ) u_tx_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tx_load),
    .i_clear (w_tx_clear),
    .i_data  (i_rd_data),
    .i_last  (w_tx_last_d),
    .o_data  (o_tx_data),
    .o_valid (w_tx_valid),
    .o_last  (o_tx_last)
  );

  assign o_tx_valid = w_tx_valid;
  assign o_idle     = r_idle;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  assign o_core_rst = r_core_rst;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_rd_addr  = r_rd_ptr;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: core and RAM models, stream collector and
// directed/randomised capture scenarios checked against a window model.
module tb_scope_capture_ctrl;

  localparam int DEPTH = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_arm, i_cont, i_abort, i_busy, i_done, i_tx_ready;
  logic [7:0] i_adc_data, i_rd_data;
  logic       o_idle, o_start, o_stop, o_core_rst, o_wr_en, o_tx_valid, o_tx_last;
  logic [8:0] o_wr_addr, o_rd_addr;
  logic [7:0] o_wr_data, o_tx_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [DEPTH];
  logic [8:0] rx_q [$];   // {last, data} per accepted transfer
  int         wr_q [$];   // address of every RAM write
  logic [7:0] exp_q [$];  // expected window for the current capture
  int         rx_base, wr_base, last_n;

  scope_capture_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_arm      (i_arm),
    .i_cont     (i_cont),
    .i_abort    (i_abort),
    .o_idle     (o_idle),
    .o_start    (o_start),
    .o_stop     (o_stop),
    .o_core_rst (o_core_rst),
    .i_busy     (i_busy),
    .i_done     (i_done),
    .i_adc_data (i_adc_data),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_tx_last  (o_tx_last),
    .i_tx_ready (i_tx_ready)
  );

  always #5 clk = ~clk;

  // Dual-port sample RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (o_wr_en) mem[o_wr_addr] <= o_wr_data;
    i_rd_data <= mem[o_rd_addr];
  end

  // Collect accepted bytes and RAM writes away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_tx_valid && i_tx_ready && !i_abort) rx_q.push_back({o_tx_last, o_tx_data});
      if (o_wr_en) wr_q.push_back(int'(o_wr_addr));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_arm();
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
  endtask

  // Core model: wait for start, go busy, present n samples, then assert done.
  // The busy cycle that answers start is consumed by the handshake.
  task automatic capture(input int n, input bit ramp);
    int t;
    logic [7:0] v;
    t = 0;
    rx_base = rx_q.size();
    wr_base = wr_q.size();
    last_n  = n;
    exp_q.delete();
    while (!o_start && t < 50) begin
      tick();
      t++;
    end
    chk("start_seen", o_start, 1);
    i_busy     = 1'b1;
    i_adc_data = 8'hEE;
    tick();
    chk("start_dropped", o_start, 0);
    for (int i = 0; i < n; i++) begin
      v          = ramp ? 8'(i) : 8'($urandom);
      i_adc_data = v;
      exp_q.push_back(v);
      tick();
    end
    i_busy = 1'b0;
    i_done = 1'b1;
    tick();
    // Only the newest DEPTH samples survive in the circular buffer.
    while (exp_q.size() > DEPTH) void'(exp_q.pop_front());
  endtask

  // Accept the stream with random ready until the core release request.
  task automatic drain(input bit bp);
    int budget, bad, lasts, nrx, wbad;
    bit held;
    logic [7:0] d0;
    budget = 0;
    held   = 0;
    i_arm  = 1'b1;  // must be ignored outside idle
    tick();
    i_arm = 1'b0;
    while (!o_stop && budget < 8000) begin
      if (bp && !held && (rx_q.size() - rx_base) >= 20 && o_tx_valid) begin
        held       = 1;
        i_tx_ready = 1'b0;
        d0         = o_tx_data;
        for (int k = 0; k < 10; k++) begin
          tick();
          chk("bp_valid", o_tx_valid, 1);
          chk("bp_data", o_tx_data, d0);
        end
      end
      i_tx_ready = ($urandom_range(0, 3) != 0);
      tick();
      budget++;
    end
    i_tx_ready = 1'b0;
    chk("drain_timeout", (budget < 8000), 1);
    nrx = rx_q.size() - rx_base;
    chk("rx_len", nrx, exp_q.size());
    bad   = 0;
    lasts = 0;
    for (int i = 0; i < nrx && i < exp_q.size(); i++) begin
      if (rx_q[rx_base+i][7:0] !== exp_q[i]) bad++;
      if (rx_q[rx_base+i][8]) lasts++;
    end
    chk("rx_data_mismatches", bad, 0);
    chk("rx_last_count", lasts, 1);
    if (nrx > 0) chk("rx_last_final", rx_q[rx_base+nrx-1][8], 1);
    chk("wr_count", wr_q.size() - wr_base, last_n);
    wbad = 0;
    for (int i = wr_base; i < wr_q.size(); i++) if (wr_q[i] != (i - wr_base) % DEPTH) wbad++;
    chk("wr_addr_mismatches", wbad, 0);
  endtask

  // Hold done for a few cycles, then drop it and check where the FSM went.
  task automatic release_core(input bit rearm);
    for (int k = 0; k < 3; k++) begin
      chk("stop_held", o_stop, 1);
      tick();
    end
    i_done = 1'b0;
    tick();
    chk("stop_dropped", o_stop, 0);
    chk("idle_after_release", o_idle, !rearm);
    chk("start_after_release", o_start, rearm);
  endtask

  initial begin
    int t, nb;
    rst        = 1'b1;
    i_arm      = 1'b0;
    i_cont     = 1'b0;
    i_abort    = 1'b0;
    i_busy     = 1'b0;
    i_done     = 1'b0;
    i_adc_data = '0;
    i_tx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_idle", o_idle, 1);
    chk("rst_ctl", {o_start, o_stop, o_core_rst, o_wr_en, o_tx_valid, o_tx_last}, 0);
    chk("rst_addr", {o_wr_addr, o_rd_addr, o_wr_data, o_tx_data}, 0);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", o_idle, 1);

    // Single shot with wrap: newest 512 ramp samples, oldest first.
    pulse_arm();
    chk("armed_not_idle", o_idle, 0);
    capture(600, 1);
    drain(0);
    release_core(0);

    // Short capture with a backpressure window.
    pulse_arm();
    capture(100, 1);
    drain(1);
    release_core(0);

    // Continuous mode: second capture re-arms without i_arm.
    i_cont = 1'b1;
    pulse_arm();
    capture(150, 0);
    drain(0);
    release_core(1);
    capture(520, 0);
    drain(0);
    i_cont = 1'b0;
    release_core(0);

    // Abort while a byte is offered, with ready in the same cycle.
    pulse_arm();
    capture(50, 0);
    t = 0;
    while (!o_tx_valid && t < 20) begin
      tick();
      t++;
    end
    chk("abort_valid_seen", o_tx_valid, 1);
    nb         = rx_q.size();
    i_abort    = 1'b1;
    i_tx_ready = 1'b1;
    tick();
    i_abort    = 1'b0;
    i_tx_ready = 1'b0;
    i_done     = 1'b0;
    chk("abort_core_rst", o_core_rst, 1);
    chk("abort_tx_valid", o_tx_valid, 0);
    chk("abort_idle", o_idle, 1);
    chk("abort_ctl", {o_start, o_stop, o_wr_en}, 0);
    chk("abort_rd_addr", o_rd_addr, 0);
    tick();
    chk("abort_core_rst_once", o_core_rst, 0);
    chk("abort_byte_not_counted", rx_q.size(), nb);
    pulse_arm();
    capture(30, 0);
    drain(0);
    release_core(0);

    // Asynchronous reset in the middle of a capture.
    pulse_arm();
    i_busy = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      i_adc_data = 8'($urandom);
      tick();
    end
    chk("pre_rst_busy_writing", o_wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_idle", o_idle, 1);
    chk("async_rst_ctl", {o_start, o_stop, o_core_rst, o_wr_en, o_tx_valid, o_tx_last}, 0);
    chk("async_rst_addr", {o_wr_addr, o_rd_addr}, 0);
    i_busy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", o_idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
